uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
//  RS232 receiver for 8N1-style serial frames, using 16x oversampling driven by a shared baud-rate tick.
//  Synchronises the asynchronous RX line and hunts for a start-bit falling edge.
//  Samples each data bit at mid-bit, LSB first, then checks the stop bit.
//  Holds the received byte with a valid/ack handshake, plus framing-error and overrun flags.
//  Pairs with the RS232 transmitter; both run from the same baud-tick generator.
// PARAMETERS
//  DBIT       8   number of data bits per frame (1..8), LSB first
//  STOP_TICK  16  baud ticks from last data sample to stop-bit sample (16 = 1 stop bit)
// PORTS
//  iCLK_50          in   1  system clock, 50 MHz
//  iRST_N           in   1  reset, asynchronous, active-low
//  iRX              in   1  serial line, asynchronous to iCLK_50, idle high
//  iBAUD_RATE_TICK  in   1  one-clock strobe at 16x baud rate
//  iRD_ACK          in   1  consumer has taken oDATA; clears oDATA_VALID and oOVERRUN
//  oDATA            out  8  received word, right-justified, bits above DBIT-1 zero
//  oDATA_VALID      out  1  oDATA holds an unread word
//  oRX_DONE_TICK    out  1  one-clock pulse when a frame completes
//  oFRAME_ERR       out  1  stop-bit sample of the last frame was 0
//  oOVERRUN         out  1  a new frame arrived while oDATA_VALID=1 and was not acked
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; oDATA=0.
//   - State idle; s, n and shift register 0.
//   - 2-flop synchroniser and previous-RX flop set to 1.
//  Synchroniser: iRX passes a 2-flop synchroniser to give rx_s. All decisions use rx_s (2-clock latency).
//  FSM states are idle, start, data and stop. s is a 4-bit tick counter and n a 3-bit bit counter.
//  All counting advances only on cycles with iBAUD_RATE_TICK=1. With no ticks, the FSM holds.
//  idle:
//   - Move to start with s=0 on a falling edge only (rx_s_prev=1, rx_s=0).
//   - A line held low never retriggers.
//  start:
//   - On a tick with s==7: if the sample is 0, go to data with s=0, n=0.
//   - If the sample is 1 at s==7 (glitch), return to idle with no outputs.
//   - On other ticks, s++.
//  data:
//   - On a tick with s==15: shift the sample into bit DBIT-1 (right shift), set s=0.
//   - If n==DBIT-1, go to stop; else n++.
//   - On other ticks, s++.
//  stop:
//   - On a tick with s==STOP_TICK-1, go to idle and, in that same clock:
//     - pulse oRX_DONE_TICK;
//     - oDATA <= shift register;
//     - oFRAME_ERR <= ~sample;
//     - oDATA_VALID <= 1;
//     - oOVERRUN <= 1 if oDATA_VALID was already 1 and iRD_ACK=0.
//   - On other ticks, s++.
//  A frame with a framing error is still delivered: data is updated and valid is set.
//  Handshake:
//   - iRD_ACK with no completion in the same clock clears oDATA_VALID and oOVERRUN next clock.
//   - Completion coinciding with iRD_ACK: the completion wins. oDATA_VALID stays 1, new data is loaded, oOVERRUN=0.
//   - iRD_ACK while oDATA_VALID=0 has no effect.
//  oFRAME_ERR holds until the next completion.
//  Reset mid-frame: the frame is aborted immediately and all outputs return to reset values. No oRX_DONE_TICK.
//  Latency: oRX_DONE_TICK fires 1 clock after the baud tick that samples the stop bit, plus 2 synchroniser clocks.
// CONFIGURATION
//  UART_RX_MAJORITY_EN
//   - Defined: every sample (start confirm, data, stop) is the 2-of-3 majority of rx_s.
//     - rx_s is captured on ticks at s = K-2, K-1 and K, where K is 7, 15 or STOP_TICK-1.
//     - Any single-tick glitch inside the window is rejected.
//   - Undefined: a single sample of rx_s on the tick at s==K; the majority logic is not built.
// TESTING
//  1. Baud tick every 4 clocks; send 0x55 with a good stop bit.
//     -> Exactly one oRX_DONE_TICK; oDATA=0x55, oDATA_VALID=1, oFRAME_ERR=0.
//  2. RX low for 4 ticks, then high.
//     -> No oRX_DONE_TICK; FSM back in idle; a following 0x3C is received correctly.
//  3. Send 0xA3 with the stop bit driven 0.
//     -> oDATA=0xA3, oFRAME_ERR=1; RX held low afterwards starts no new frame until it returns high.
//  4. Send 0x11 then 0x22 with no ack.
//     -> oDATA=0x22, oOVERRUN=1; iRD_ACK -> oDATA_VALID=0, oOVERRUN=0.
//  5. iRD_ACK asserted in the same clock as the 0x7E completion.
//     -> oDATA=0x7E, oDATA_VALID=1, oOVERRUN=0.
//  6. iRST_N pulsed low during data bit 3.
//     -> All outputs 0, no done pulse; next frame 0xC3 is received correctly.
//     With UART_RX_MAJORITY_EN: a 1-tick glitch at s==14 of bit 2 leaves oDATA=0xC3.

Source files
------------

// File: rtl/uart_rx_ovs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_ovs
// Purpose  : 8N1-style RS232 receiver using 16x oversampling from a shared
//            baud-rate tick. A 2-flop synchroniser feeds a falling-edge hunter.
//            Data bits are sampled at mid-bit, LSB first, and the stop bit is
//            then checked. The received word is held behind a valid/ack
//            handshake, with framing-error and overrun flags.
// Ports    : iCLK_50          system clock (50 MHz)
//            iRST_N           asynchronous active-low reset
//            iRX              serial line, asynchronous, idle high
//            iBAUD_RATE_TICK  one-clock strobe at 16x baud rate
//            iRD_ACK          consumer took oDATA; clears valid/overrun
//            oDATA[7:0]       received word, right-justified
//            oDATA_VALID      oDATA holds an unread word
//            oRX_DONE_TICK    one-clock pulse per completed frame
//            oFRAME_ERR       stop-bit sample of last frame was 0
//            oOVERRUN         a frame completed while an unread word was held
// Options  : `define UART_RX_MAJORITY_EN  -> each bit decision is the 2-of-3
//            majority of rx_s taken on ticks s = K-2, K-1, K.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ovs #(
    parameter int DBIT      = 8,
    parameter int STOP_TICK = 16
) (
    input  logic       iCLK_50,
    input  logic       iRST_N,
    input  logic       iRX,
    input  logic       iBAUD_RATE_TICK,
    input  logic       iRD_ACK,
    output logic [7:0] oDATA,
    output logic       oDATA_VALID,
    output logic       oRX_DONE_TICK,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN
);

    localparam logic [3:0] c_START_LAST = 4'd7;
    localparam logic [3:0] c_DATA_LAST  = 4'd15;
    localparam logic [3:0] c_STOP_LAST  = 4'(STOP_TICK - 1);
    localparam logic [2:0] c_BIT_LAST   = 3'(DBIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_prev;
    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_s;
    logic [3:0] w_s_next;
    logic [2:0] r_n;
    logic [2:0] w_n_next;
    logic [7:0] r_shift;
    logic [7:0] w_shift_next;
    logic       w_sample;
    logic       w_complete;

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_done;
    logic       r_ferr;
    logic       r_ovr;

    // Synchroniser; the previous-RX flop only moves on ticks so that the
    // idle edge hunt compares two consecutive tick-rate samples.
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= iRX;
            r_rx_s    <= r_rx_meta;
            if (iBAUD_RATE_TICK) begin
                r_rx_prev <= r_rx_s;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two earlier samples are kept; the third is rx_s on the deciding tick.
    logic [3:0] w_k;
    logic [1:0] r_win;

    always_comb begin
        w_k = c_START_LAST;
        case (r_state)
            ST_DATA: w_k = c_DATA_LAST;
            ST_STOP: w_k = c_STOP_LAST;
            default: w_k = c_START_LAST;
        endcase
    end

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_win <= 2'b11;
        end else if (iBAUD_RATE_TICK && (r_state != ST_IDLE) &&
                     ((r_s == (w_k - 4'd2)) || (r_s == (w_k - 4'd1)))) begin
            r_win <= {r_win[0], r_rx_s};
        end
    end

    assign w_sample = (r_win[1] & r_win[0]) | (r_win[1] & r_rx_s) | (r_win[0] & r_rx_s);
`else
    assign w_sample = r_rx_s;
`endif

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
            r_s     <= 4'd0;
            r_n     <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_shift_next = r_shift;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Falling edge only: a line stuck low never restarts a frame.
                if (iBAUD_RATE_TICK && r_rx_prev && !r_rx_s) begin
                    w_state_next = ST_START;
                    w_s_next     = 4'd0;
                end
            end
            ST_START: begin
                if (iBAUD_RATE_TICK) begin
                    if (r_s == c_START_LAST) begin
                        w_s_next = 4'd0;
                        if (!w_sample) begin
                            w_state_next = ST_DATA;
                            w_n_next     = 3'd0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (iBAUD_RATE_TICK) begin
                    if (r_s == c_DATA_LAST) begin
                        w_s_next = 4'd0;
                        // New bit enters at the top; after DBIT shifts the
                        // word sits right-justified with zeros above it.
                        w_shift_next         = r_shift >> 1;
                        w_shift_next[DBIT-1] = w_sample;
                        if (r_n == c_BIT_LAST) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + 3'd1;
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (iBAUD_RATE_TICK) begin
                    if (r_s == c_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_s_next     = 4'd0;
                        w_complete   = 1'b1;
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_s_next     = 4'd0;
            end
        endcase
    end

    // Completion takes priority over a coincident acknowledge.
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_complete) begin
                r_data  <= r_shift;
                r_ferr  <= ~w_sample;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~iRD_ACK;
            end else if (iRD_ACK) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign oDATA         = r_data;
    assign oDATA_VALID   = r_valid;
    assign oRX_DONE_TICK = r_done;
    assign oFRAME_ERR    = r_ferr;
    assign oOVERRUN      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ovs
// Purpose  : Scoreboard bench for uart_rx_ovs. Frames are pushed as expected
//            responses when sent; a monitor pops one per oRX_DONE_TICK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ovs;

    localparam int BIT_CLKS = 64;   // 16 ticks x 4 clocks per tick

    logic       iCLK_50 = 1'b0;
    logic       iRST_N  = 1'b0;
    logic       iRX     = 1'b1;
    logic       iRD_ACK = 1'b0;
    logic       iBAUD_RATE_TICK;
    logic [7:0] oDATA;
    logic       oDATA_VALID;
    logic       oRX_DONE_TICK;
    logic       oFRAME_ERR;
    logic       oOVERRUN;

    int unsigned clk_cnt = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit model_valid = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       ovr;
    } exp_t;
    exp_t sb[$];

    uart_rx_ovs dut (
        .iCLK_50         (iCLK_50),
        .iRST_N          (iRST_N),
        .iRX             (iRX),
        .iBAUD_RATE_TICK (iBAUD_RATE_TICK),
        .iRD_ACK         (iRD_ACK),
        .oDATA           (oDATA),
        .oDATA_VALID     (oDATA_VALID),
        .oRX_DONE_TICK   (oRX_DONE_TICK),
        .oFRAME_ERR      (oFRAME_ERR),
        .oOVERRUN        (oOVERRUN)
    );

    always #10 iCLK_50 = ~iCLK_50;
    always @(posedge iCLK_50) clk_cnt <= clk_cnt + 1;
    // Tick is high across every fourth rising edge.
    assign iBAUD_RATE_TICK = ((clk_cnt % 4) == 3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected frame.
    always @(negedge iCLK_50) begin
        if (oRX_DONE_TICK === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got frame 0x%0h, expected no frame", oDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_data",  {24'd0, oDATA}, {24'd0, e.data});
                check("done_ferr",  {31'd0, oFRAME_ERR}, {31'd0, e.ferr});
                check("done_ovr",   {31'd0, oOVERRUN}, {31'd0, e.ovr});
                check("done_valid", {31'd0, oDATA_VALID}, 32'd1);
            end
        end
    end

    // Wait until the negedge directly following a tick edge.
    task automatic align();
        @(negedge iCLK_50);
        while ((clk_cnt % 4) != 0) @(negedge iCLK_50);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge iCLK_50);
    endtask

    // Sends one frame. Relative to the start bit set just after tick edge P0,
    // the stop bit is sampled on the tick at P612 (36 clocks into the stop
    // bit), and the s==14 tick of data bit 2 lies at P224.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input bit ack_at_done, input int glitch_bit);
        exp_t e;
        e.data = d;
        e.ferr = ~stop_bit;
        e.ovr  = model_valid && !ack_at_done;
        sb.push_back(e);
        model_valid = 1'b1;
        align();
        iRX = 1'b0;
        wait_clks(BIT_CLKS);
        for (int b = 0; b < 8; b++) begin
            iRX = d[b];
            if (b == glitch_bit) begin
                wait_clks(29);
                iRX = ~d[b];
                wait_clks(4);
                iRX = d[b];
                wait_clks(BIT_CLKS - 33);
            end else begin
                wait_clks(BIT_CLKS);
            end
        end
        iRX = stop_bit;
        if (ack_at_done) begin
            wait_clks(35);
            iRD_ACK = 1'b1;
            wait_clks(1);
            iRD_ACK = 1'b0;
            wait_clks(BIT_CLKS - 36);
        end else begin
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic ack();
        @(negedge iCLK_50);
        iRD_ACK = 1'b1;
        @(negedge iCLK_50);
        iRD_ACK = 1'b0;
        model_valid = 1'b0;
        @(negedge iCLK_50);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  {24'd0, oDATA}, 32'd0);
        check({tag, "_valid"}, {31'd0, oDATA_VALID}, 32'd0);
        check({tag, "_done"},  {31'd0, oRX_DONE_TICK}, 32'd0);
        check({tag, "_ferr"},  {31'd0, oFRAME_ERR}, 32'd0);
        check({tag, "_ovr"},   {31'd0, oOVERRUN}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int glitch;
        glitch = -1;
        wait_clks(3);
        check_outputs_zero("reset");
        iRST_N = 1'b1;
        wait_clks(8);

        // 1: clean 0x55
        send_frame(8'h55, 1'b1, 1'b0, -1);
        wait_clks(16);
        check("t1_valid", {31'd0, oDATA_VALID}, 32'd1);
        check("t1_data",  {24'd0, oDATA}, 32'h55);
        ack();
        check("t1_ack_valid", {31'd0, oDATA_VALID}, 32'd0);
        ack();   // ack with nothing held changes nothing
        check("t1_idle_ack_ovr", {31'd0, oOVERRUN}, 32'd0);

        // 2: 4-tick low pulse is rejected, then 0x3C
        align();
        iRX = 1'b0;
        wait_clks(16);
        iRX = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("t2_no_frame_valid", {31'd0, oDATA_VALID}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        wait_clks(16);
        check("t2_data", {24'd0, oDATA}, 32'h3C);
        ack();

        // 3: 0xA3 with bad stop bit, line then held low
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        wait_clks(4 * BIT_CLKS);
        check("t3_data", {24'd0, oDATA}, 32'hA3);
        check("t3_ferr", {31'd0, oFRAME_ERR}, 32'd1);
        iRX = 1'b1;
        wait_clks(BIT_CLKS);
        ack();

        // 4: overrun
        send_frame(8'h11, 1'b1, 1'b0, -1);
        iRX = 1'b1;
        send_frame(8'h22, 1'b1, 1'b0, -1);
        wait_clks(16);
        check("t4_data", {24'd0, oDATA}, 32'h22);
        check("t4_ovr",  {31'd0, oOVERRUN}, 32'd1);
        check("t4_ferr", {31'd0, oFRAME_ERR}, 32'd0);
        ack();
        check("t4_ack_valid", {31'd0, oDATA_VALID}, 32'd0);
        check("t4_ack_ovr",   {31'd0, oOVERRUN}, 32'd0);

        // 5: ack coinciding with completion while a word is held
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        wait_clks(16);
        check("t5_data",  {24'd0, oDATA}, 32'h7E);
        check("t5_valid", {31'd0, oDATA_VALID}, 32'd1);
        check("t5_ovr",   {31'd0, oOVERRUN}, 32'd0);

        // 6: reset during data bit 3, word still held from test 5
        align();
        iRX = 1'b0;
        wait_clks(BIT_CLKS);
        iRX = 1'b1;
        wait_clks(3 * BIT_CLKS + 32);
        iRST_N = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        wait_clks(3);
        iRST_N = 1'b1;
        model_valid = 1'b0;
        wait_clks(3 * BIT_CLKS);
        check_outputs_zero("t6_after");
`ifdef UART_RX_MAJORITY_EN
        glitch = 2;
`endif
        send_frame(8'hC3, 1'b1, 1'b0, glitch);
        wait_clks(BIT_CLKS);
        check("t6_data",  {24'd0, oDATA}, 32'hC3);
        check("t6_valid", {31'd0, oDATA_VALID}, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
